// File: rtl/accum_bcd_display_pkg.sv
// accum_bcd_display_pkg: FSM states, active-low segment patterns and digit encoder
package accum_bcd_display_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LATCH = 2'd2} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/accum_bcd_display_if.sv
// accum_bcd_display_if: accumulator input and display output bundle
interface accum_bcd_display_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] value;
  logic             ovf_in;
  logic [6:0]       hex0;
  logic [6:0]       hex1;
  logic [6:0]       hex2;
  logic             ovf_led;
  logic             busy;
  logic             done;
  modport master(output value, ovf_in, input hex0, hex1, hex2, ovf_led, busy, done);
  modport slave(input value, ovf_in, output hex0, hex1, hex2, ovf_led, busy, done);
endinterface

// File: rtl/accum_bcd_display_seg7_decoder.sv
// accum_bcd_display_seg7_decoder: BCD digit to active-low 7-segment pattern
module accum_bcd_display_seg7_decoder
  import accum_bcd_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  assign o_seg = i_blank ? SEG_BLANK : seg7(i_digit);
endmodule

// File: rtl/accum_bcd_display.sv
// accum_bcd_display: sequential double-dabble of the accumulator sum onto three 7-segment digits
module accum_bcd_display
  import accum_bcd_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic clk,
  input logic clr,
  accum_bcd_display_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t                  r_state;
  logic [WIDTH-1:0]        r_bin_sr;
  logic [4*DIGITS-1:0]     r_bcd;
  logic [4*DIGITS-1:0]     w_adj;
  logic [CW-1:0]           r_cnt;
  logic [WIDTH:0]          r_snap;
  logic                    r_snap_valid;
  logic [DIGITS-1:0][6:0]  r_hex;
  logic [DIGITS-1:0][6:0]  w_seg;
  logic [DIGITS-1:0]       w_blank;
  logic                    r_ovf_led;
  logic                    r_done;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [3:0] w_nib;
    assign w_nib = r_bcd[4*d +: 4];
    assign w_adj[4*d +: 4] = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
    // a digit blanks only when it and every more significant digit are zero
    assign w_blank[d] = BLANK_LZ && (d != 0) && (r_bcd[4*DIGITS-1:4*d] == '0);
    accum_bcd_display_seg7_decoder u_dec (
      .i_digit(w_nib),
      .i_blank(w_blank[d]),
      .o_seg  (w_seg[d])
    );
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= IDLE;
      r_bin_sr     <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_snap       <= '0;
      r_snap_valid <= 1'b0;
      r_hex        <= {DIGITS{SEG_BLANK}};
      r_ovf_led    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_snap_valid || {bus.ovf_in, bus.value} != r_snap) begin
            r_bin_sr     <= bus.value;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_snap       <= {bus.ovf_in, bus.value};
            r_snap_valid <= 1'b1;
            r_state      <= SHIFT;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin_sr} <= {w_adj, r_bin_sr} << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= LATCH;
        end
        LATCH: begin
          r_hex     <= w_seg;
          r_ovf_led <= r_snap[WIDTH];
          r_done    <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.hex0    = r_hex[0];
  assign bus.hex1    = r_hex[1];
  assign bus.hex2    = r_hex[2];
  assign bus.ovf_led = r_ovf_led;
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
endmodule

// File: tb/tb_accum_bcd_display.sv
// tb_accum_bcd_display: randomized and directed checks against a decimal display model
module tb_accum_bcd_display;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int checks = 0;
  int errors = 0;
  int busy_cycles;
  int dones;
  logic [6:0] first_h0, first_h1, first_h2;
  logic [8:0] prev = 9'h1FF;
  accum_bcd_display_if #(.WIDTH(8)) bus ();
  accum_bcd_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] exp_seg(input int v, input int d);
    logic [6:0] tab [10];
    int p;
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    p = (d == 0) ? 1 : (d == 1) ? 10 : 100;
    if (d > 0 && v < p) return 7'h7F;
    return tab[(v / p) % 10];
  endfunction
  task automatic run_cycles(input int n);
    busy_cycles = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        if (dones == 0) begin
          first_h0 = bus.hex0;
          first_h1 = bus.hex1;
          first_h2 = bus.hex2;
        end
        dones++;
      end
    end
  endtask
  task automatic test_reset;
    bus.value = 8'd0;
    bus.ovf_in = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    run_cycles(20);
    bus.value = 8'd77;
    repeat (3) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({bus.hex2, bus.hex1, bus.hex0} !== {3{7'h7F}}) begin
      errors++;
      $display("FAIL reset_hex got %h %h %h exp 7f 7f 7f", bus.hex2, bus.hex1, bus.hex0);
    end
    checks++;
    if ({bus.ovf_led, bus.busy, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got ovf=%b busy=%b done=%b exp 000", bus.ovf_led, bus.busy, bus.done);
    end
    bus.value = 8'd0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    run_cycles(20);
    checks++;
    if (dones !== 1 || {bus.hex2, bus.hex1, bus.hex0} !== {7'h7F, 7'h7F, 7'h40}) begin
      errors++;
      $display("FAIL reset_rerun got dones=%0d hex=%h %h %h exp 1 7f 7f 40", dones, bus.hex2, bus.hex1, bus.hex0);
    end
    prev = 9'd0;
  endtask
  task automatic test_convert(input int v, input logic o);
    bus.value = v[7:0];
    bus.ovf_in = o;
    prev = {o, v[7:0]};
    run_cycles(25);
    checks++;
    if (busy_cycles !== 9 || dones !== 1) begin
      errors++;
      $display("FAIL conv_timing v=%0d got busy=%0d done=%0d exp 9 1", v, busy_cycles, dones);
    end
    checks++;
    if ({bus.hex2, bus.hex1, bus.hex0} !== {exp_seg(v, 2), exp_seg(v, 1), exp_seg(v, 0)}) begin
      errors++;
      $display("FAIL conv_digits v=%0d got %h %h %h exp %h %h %h", v, bus.hex2, bus.hex1, bus.hex0,
               exp_seg(v, 2), exp_seg(v, 1), exp_seg(v, 0));
    end
    checks++;
    if (bus.ovf_led !== o) begin
      errors++;
      $display("FAIL conv_ovf v=%0d got %b exp %b", v, bus.ovf_led, o);
    end
  endtask
  task automatic test_random;
    int v;
    logic o;
    for (int k = 0; k < 8; k++) begin
      do begin
        v = int'($urandom_range(0, 255));
        o = 1'($urandom_range(0, 1));
      end while ({o, v[7:0]} == prev);
      test_convert(v, o);
    end
  endtask
  task automatic test_back_to_back;
    bus.value = 8'd10;
    bus.ovf_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.value = 8'd200;
    run_cycles(30);
    prev = {1'b0, 8'd200};
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL b2b_dones got %0d exp 2", dones);
    end
    checks++;
    if ({first_h2, first_h1, first_h0} !== {exp_seg(10, 2), exp_seg(10, 1), exp_seg(10, 0)}) begin
      errors++;
      $display("FAIL b2b_first got %h %h %h exp %h %h %h", first_h2, first_h1, first_h0,
               exp_seg(10, 2), exp_seg(10, 1), exp_seg(10, 0));
    end
    checks++;
    if ({bus.hex2, bus.hex1, bus.hex0} !== {exp_seg(200, 2), exp_seg(200, 1), exp_seg(200, 0)}) begin
      errors++;
      $display("FAIL b2b_final got %h %h %h exp %h %h %h", bus.hex2, bus.hex1, bus.hex0,
               exp_seg(200, 2), exp_seg(200, 1), exp_seg(200, 0));
    end
  endtask
  task automatic test_ovf_retrigger;
    test_convert(4, 1'b1);
    test_convert(4, 1'b0);
    run_cycles(12);
    checks++;
    if (busy_cycles !== 0 || dones !== 0) begin
      errors++;
      $display("FAIL idle_hold got busy=%0d done=%0d exp 0 0", busy_cycles, dones);
    end
  endtask
  initial begin
    bus.value = 8'd0;
    bus.ovf_in = 1'b0;
    test_reset;
    test_convert(255, 1'b0);
    test_convert(7, 1'b0);
    test_convert(105, 1'b0);
    test_convert(100, 1'b1);
    test_back_to_back;
    test_ovf_retrigger;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
